// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle for booth_mult_seq.
// Both channels use valid/ready: a transfer happens on a rising edge where valid && ready.
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, result, busy, done
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, result, busy, done
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock over a shared add/sub.
// Optional macro BOOTH_EARLY_TERM_EN collapses trailing all-equal multiplier bits into one shift.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    booth_mult_seq_if.slave  bus,
    output logic [1:0]       state_dbg
);
    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]   a_q, q_q, m_q;
    logic             qm1_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   a_ext, b_ext, sum, a_step, q_step;
    logic [WIDTH:0]   a_adv, q_adv;
    logic             qm1_adv;
    logic [CNT_W-1:0] cnt_adv;
    logic             last_step;
    logic             accept;

    assign accept = bus.in_valid && (state_q == IDLE);

    // One extra operand bit lets signed and unsigned share the same Booth datapath.
    always_comb begin
        a_ext = bus.in_signed ? {bus.in_a[WIDTH-1], bus.in_a} : {1'b0, bus.in_a};
        b_ext = bus.in_signed ? {bus.in_b[WIDTH-1], bus.in_b} : {1'b0, bus.in_b};
        case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        a_step = {sum[WIDTH], sum[WIDTH:1]};
        q_step = {sum[0], q_q[WIDTH:1]};
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH:0]            live_mask;
    logic                      early_term;
    logic signed [2*WIDTH+1:0] aq_jump;

    // Remaining steps are pure shifts when every unconsumed bit equals q_-1.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            live_mask[i] = (CNT_W'(i) < cnt_q);
        end
        early_term = (((q_q & live_mask) == '0) && !qm1_q) ||
                     (((q_q & live_mask) == live_mask) && qm1_q);
        aq_jump    = $signed({a_q, q_q}) >>> cnt_q;
        if (early_term) begin
            a_adv     = aq_jump[2*WIDTH+1:WIDTH+1];
            q_adv     = aq_jump[WIDTH:0];
            qm1_adv   = 1'b0;
            cnt_adv   = '0;
            last_step = 1'b1;
        end else begin
            a_adv     = a_step;
            q_adv     = q_step;
            qm1_adv   = q_q[0];
            cnt_adv   = cnt_q - 1'b1;
            last_step = (cnt_q == CNT_W'(1));
        end
    end
`else
    assign a_adv     = a_step;
    assign q_adv     = q_step;
    assign qm1_adv   = q_q[0];
    assign cnt_adv   = cnt_q - 1'b1;
    assign last_step = (cnt_q == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rst;
        bus.busy      = (state_q == BUSY);
        bus.out_valid = (state_q == DONE);
        bus.done      = (state_q == DONE) && bus.out_ready;
        bus.result    = (state_q == DONE) ? {a_q[WIDTH-2:0], q_q} : '0;
        state_dbg     = state_q;
    end

    // Datapath registers; operands are only sampled on the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= '0;
            q_q   <= b_ext;
            m_q   <= a_ext;
            qm1_q <= 1'b0;
            cnt_q <= CNT_W'(WIDTH + 1);
        end else if (state_q == BUSY) begin
            a_q   <= a_adv;
            q_q   <= q_adv;
            qm1_q <= qm1_adv;
            cnt_q <= cnt_adv;
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table, corner sequences, random sweep.
// Expected products come from plain 64-bit arithmetic, not from the Booth algorithm.
module tb_booth_mult_seq;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] state_dbg;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    int busy_cnt = 0;
    int last_busy = 0;
    int hs_cnt = 0;
    logic prev_busy = 1'b0;
    logic prev_ov = 1'b0;
    bit rand_ready = 1'b0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0] ua, ub;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_ov   = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.out_valid && !prev_ov) begin
                chk("out_valid_after_busy", 64'(prev_busy), 64'd1);
`ifndef BOOTH_EARLY_TERM_EN
                chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));
`endif
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("done_pulse", 64'(bus.done), 64'd1);
                chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected no output", bus.result);
                end else begin
                    chk("result", bus.result, exp_q.pop_front());
                end
                last_busy = busy_cnt;
                busy_cnt  = 0;
                hs_cnt++;
            end
            prev_busy = bus.busy;
            prev_ov   = bus.out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] e, input bit keep);
        bit ok = 1'b0;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 300 cycles");
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        logic [W-1:0] ra, rb;
        logic rs;

        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[5] = '{32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[6] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000};
        vecs[7] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F};
        vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
        vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Vector table
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0);
            wait_drain();
        end

        // Stalled output: held stable, then a single done pulse
        bus.out_ready = 1'b0;
        send(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        wait_out_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_result", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("in_ready_after_done", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of BUSY with in_valid still high
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0), 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_no_output", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(32'd3, 32'd5, 1'b0, 64'd15, 1'b0);
        wait_drain();

        // Back-to-back: in_valid held high across a completion
        send(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, ref_mul(32'hDEAD_BEEF, 32'h0000_1234, 1'b0), 1'b1);
        hs0 = hs_cnt;
        send(32'hFFFF_FF00, 32'h0000_0100, 1'b1, ref_mul(32'hFFFF_FF00, 32'h0000_0100, 1'b1), 1'b0);
        chk("b2b_second_after_first", 64'(hs_cnt), 64'(hs0 + 1));
        wait_drain();

`ifdef BOOTH_EARLY_TERM_EN
        send(32'h0001_2345, 32'd0, 1'b1, 64'd0, 1'b0);
        wait_drain();
        chk("et_zero_busy", 64'(last_busy), 64'd1);
        send(32'd5, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        wait_drain();
        checks++;
        if (last_busy >= W + 1) begin
            errors++;
            $display("FAIL et_minus_one_busy: got %0d expected fewer than %0d", last_busy, W + 1);
        end
`endif

        // Random sweep with random output back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, ref_mul(ra, rb, rs), 1'b0);
            bus.in_a      = $urandom();
            bus.in_b      = $urandom();
            bus.in_signed = ~rs;
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        wait_drain();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
